ped_request_ctrl: RTL and testbench

- Front end of the pedestrian crossing path.
- Debounces the raw crosswalk push-button and raises a request to the main traffic FSM.
- After grant, times the walk phase, then a flashing clearance phase. Drives ped_signal, which is the select for the walk-light mux.
- Reports remaining seconds and signals completion back to the traffic FSM.

---
 rtl/ped_request_ctrl.sv | 126 ++++++++++++
 tb/tb_ped_request_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian request front end: button debounce, walk/clear timing
// Outputs are decoded from registered state only, so no input reaches an output combinationally.
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_TIME       = 6,
  parameter int CLEAR_TIME      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       button_raw,
  input  logic       grant,
  output logic       ped_req,
  output logic       ped_signal,
  output logic       ped_flash,
  output logic       ped_done,
  output logic [6:0] time_left,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, REQ, WALK, CLEAR, DONE} state_t;

  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES);
  localparam logic [6:0] WALK_T  = 7'(WALK_TIME);
  localparam logic [6:0] CLEAR_T = 7'(CLEAR_TIME);

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic [7:0] deb_q, deb_d;
  logic [6:0] time_q, time_d;
  logic       flash_q, flash_d;
  logic       pending_q, pending_d;
  logic       press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 8'd0;
      state_q   <= IDLE;
      time_q    <= 7'd0;
      flash_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= button_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      state_q   <= state_d;
      time_q    <= time_d;
      flash_q   <= flash_d;
      pending_q <= pending_d;
    end
  end

  // press fires only on the step into saturation, so a held button yields one event
  always_comb begin
    deb_d = deb_q;
    press = 1'b0;
    if (!sync2_q) begin
      deb_d = 8'd0;
    end else if (deb_q != DEB_MAX) begin
      deb_d = deb_q + 8'd1;
      press = (deb_q == DEB_MAX - 8'd1);
    end
  end

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    flash_d   = flash_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = REQ;
      end
      REQ: begin
        if (grant) begin
          state_d = WALK;
          time_d  = WALK_T;
        end
      end
      WALK: begin
        if (press) pending_d = 1'b1;
        // losing grant aborts the walk but still runs the full clearance
        if (!grant || (tick && time_q == 7'd1)) begin
          state_d = CLEAR;
          time_d  = CLEAR_T;
          flash_d = 1'b1;
        end else if (tick) begin
          time_d = time_q - 7'd1;
        end
      end
      CLEAR: begin
        if (press) pending_d = 1'b1;
        if (tick) begin
          flash_d = ~flash_q;
          if (time_q == 7'd1) begin
            state_d = DONE;
            time_d  = 7'd0;
          end else begin
            time_d = time_q - 7'd1;
          end
        end
      end
      DONE: begin
        state_d   = (pending_q || press) ? REQ : IDLE;
        pending_d = 1'b0;
        time_d    = 7'd0;
        flash_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        time_d  = 7'd0;
        flash_d = 1'b0;
      end
    endcase
  end

  assign ped_req    = (state_q == REQ) || (state_q == WALK) || (state_q == CLEAR);
  assign ped_signal = (state_q == WALK);
  assign ped_flash  = (state_q == CLEAR) && flash_q;
  assign ped_done   = (state_q == DONE);
  assign time_left  = time_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - randomized and directed bench for ped_request_ctrl
module tb_ped_request_ctrl;

  localparam int DEB = 4;
  localparam int WT  = 6;
  localparam int CT  = 3;

  logic       clk, rst, tick, button_raw, grant;
  logic       ped_req, ped_signal, ped_flash, ped_done, busy;
  logic [6:0] time_left;

  ped_request_ctrl #(.DEBOUNCE_CYCLES(DEB), .WALK_TIME(WT), .CLEAR_TIME(CT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .button_raw(button_raw), .grant(grant),
    .ped_req(ped_req), .ped_signal(ped_signal), .ped_flash(ped_flash),
    .ped_done(ped_done), .time_left(time_left), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int tick_mode = 0;
  int done_cnt = 0;

  // reference model: raw sample history, run length of synchronized highs, phase counters
  bit hist[$];
  int run_len;
  bit m_req_wait, m_done, m_pending;
  int m_walk, m_clear, m_cticks;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    run_len = 0;
    m_req_wait = 0; m_done = 0; m_pending = 0;
    m_walk = 0; m_clear = 0; m_cticks = 0;
  endtask

  task automatic model_step();
    bit s, press;
    s = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(button_raw);
    if (hist.size() > 4) void'(hist.pop_front());
    if (s) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_len = 0;
    end
    press = s && (run_len == DEB);
    if (m_done) begin
      m_done = 0;
      m_req_wait = m_pending || press;
      m_pending = 0;
    end else if (m_req_wait) begin
      if (grant) begin
        m_req_wait = 0;
        m_walk = WT;
      end
    end else if (m_walk > 0) begin
      if (press) m_pending = 1;
      if (!grant || (tick && m_walk == 1)) begin
        m_walk = 0;
        m_clear = CT;
        m_cticks = 0;
      end else if (tick) begin
        m_walk--;
      end
    end else if (m_clear > 0) begin
      if (press) m_pending = 1;
      if (tick) begin
        m_cticks++;
        m_clear--;
        if (m_clear == 0) m_done = 1;
      end
    end else if (press) begin
      m_req_wait = 1;
    end
  endtask

  task automatic compare_all();
    bit active;
    active = m_req_wait || m_walk > 0 || m_clear > 0;
    check_eq("ped_req", ped_req, active);
    check_eq("ped_signal", ped_signal, m_walk > 0);
    check_eq("ped_flash", ped_flash, (m_clear > 0) && (m_cticks % 2 == 0));
    check_eq("ped_done", ped_done, m_done);
    check_eq("time_left", time_left, (m_walk > 0) ? m_walk : m_clear);
    check_eq("busy", busy, active || m_done);
  endtask

  task automatic cycle();
    case (tick_mode)
      1:       tick = (cyc % 10 == 9);
      2:       tick = ($urandom_range(3) == 0);
      default: tick = 1'b0;
    endcase
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    if (ped_done) done_cnt++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    compare_all();
    #1;
    rst = 1'b0;
  endtask

  task automatic press_button(input int n);
    button_raw = 1'b1;
    repeat (n) cycle();
    button_raw = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 400) begin cycle(); k++; end
    check_eq(tag, k < 400, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1; tick = 1'b0; button_raw = 1'b0; grant = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // held button: request latency and a single press
    button_raw = 1'b1;
    repeat (5) cycle();
    check_eq("lat_pre", ped_req, 0);
    cycle();
    check_eq("lat_post", ped_req, 1);
    repeat (14) cycle();
    button_raw = 1'b0;
    repeat (10) cycle();
    check_eq("hold_req", ped_req, 1);
    grant = 1'b1; tick_mode = 1; done_cnt = 0;
    run_to_idle("s1_idle");
    repeat (10) cycle();
    check_eq("s1_done_cnt", done_cnt, 1);

    // short glitches never qualify
    @(negedge clk); do_reset();
    tick_mode = 0; grant = 1'b0;
    repeat (6) begin
      press_button(3);
      repeat (3) cycle();
    end
    check_eq("glitch_req", ped_req, 0);

    // full crossing with grant already high
    grant = 1'b1; tick_mode = 1; done_cnt = 0;
    press_button(6);
    run_to_idle("s3_idle");
    check_eq("s3_done_cnt", done_cnt, 1);
    check_eq("s3_time", time_left, 0);

    // grant dropped mid-walk
    press_button(6);
    k = 0;
    while (!(ped_signal && time_left == 7'd4) && k < 300) begin cycle(); k++; end
    check_eq("s4_wait", k < 300, 1);
    grant = 1'b0;
    cycle();
    check_eq("s4_signal", ped_signal, 0);
    check_eq("s4_time", time_left, CT);
    done_cnt = 0;
    k = 0;
    while (!ped_done && k < 100) begin cycle(); k++; end
    check_eq("s4_done", k < 100, 1);
    cycle();
    check_eq("s4_idle", busy, 0);

    // press during clearance re-requests after done
    grant = 1'b1;
    press_button(6);
    k = 0;
    while (!(ped_req && !ped_signal && time_left != 0) && k < 300) begin cycle(); k++; end
    check_eq("s5_wait", k < 300, 1);
    press_button(6);
    k = 0;
    while (!ped_done && k < 100) begin cycle(); k++; end
    check_eq("s5_done", k < 100, 1);
    cycle();
    check_eq("s5_rereq", ped_req, 1);
    run_to_idle("s5_idle");

    // asynchronous reset mid-walk
    press_button(6);
    k = 0;
    while (!(ped_signal && time_left == 7'd2) && k < 300) begin cycle(); k++; end
    check_eq("s6_wait", k < 300, 1);
    do_reset();
    check_eq("s6_busy", busy, 0);
    check_eq("s6_signal", ped_signal, 0);
    done_cnt = 0;
    repeat (5) cycle();
    check_eq("s6_nodone", done_cnt, 0);
    press_button(6);
    run_to_idle("s6_idle");
    check_eq("s6_done_cnt", done_cnt, 1);

    // randomized traffic
    tick_mode = 2;
    repeat (3000) begin
      if ($urandom_range(5) == 0) button_raw = ~button_raw;
      if ($urandom_range(19) == 0) grant = ~grant;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
